// File: rtl/pipelined_addsub.sv
// WIDTH-bit ripple-carry adder/subtractor split into STAGES register slices, with
// valid/ready on both sides and ARM NZCV flags produced alongside the final slice.
module pipelined_addsub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [3:0]       flags
);
    localparam int S = WIDTH / STAGES;

    // Handshake: a beat moves only on a rising edge where valid and ready are both high.
    // Valid never waits on ready; ready is a combinational chain back from out_ready,
    // so a full pipeline keeps streaming with no bubbles while out_ready stays high.

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

    // Returns {carry into slice MSB, carry out, slice sum}.
    function automatic logic [S+1:0] slice_add(input logic [S-1:0] x, input logic [S-1:0] y,
                                               input logic ci);
        logic [S-1:0] s;
        logic         c;
        logic         c_msb;
        logic [1:0]   fa;
        c     = ci;
        c_msb = ci;
        s     = '0;
        for (int i = 0; i < S; i++) begin
            c_msb = c;
            fa    = full_add(x[i], y[i], c);
            s[i]  = fa[0];
            c     = fa[1];
        end
        return {c_msb, c, s};
    endfunction

    logic [STAGES-1:0] vld;
    logic [WIDTH-1:0]  op_a [STAGES];
    logic [WIDTH-1:0]  op_b [STAGES];
    logic [WIDTH-1:0]  op_r [STAGES];
    logic              op_c [STAGES];
    logic [3:0]        flags_q;

    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_r [STAGES];
    logic              src_c [STAGES];
    logic [WIDTH-1:0]  nxt_r [STAGES];
    logic              nxt_c [STAGES];
    logic [S+1:0]      slice_res [STAGES];
    logic [3:0]        nxt_flags;
    logic              adv  [STAGES];
    logic              load [STAGES];

    // Stage 0 conditions the operands; later stages pick up the beat from their predecessor.
    always_comb begin
        src_a[0] = a;
        src_b[0] = sub ? ~b : b;
        src_c[0] = sub | c_in;
        src_r[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k] = op_a[k-1];
            src_b[k] = op_b[k-1];
            src_c[k] = op_c[k-1];
            src_r[k] = op_r[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            slice_res[k]         = slice_add(src_a[k][k*S +: S], src_b[k][k*S +: S], src_c[k]);
            nxt_r[k]             = src_r[k];
            nxt_r[k][k*S +: S]   = slice_res[k][S-1:0];
            nxt_c[k]             = slice_res[k][S];
        end
    end

    assign nxt_flags = {nxt_r[STAGES-1][WIDTH-1],
                        (nxt_r[STAGES-1] == '0),
                        nxt_c[STAGES-1],
                        slice_res[STAGES-1][S+1] ^ nxt_c[STAGES-1]};

    always_comb begin
        adv[STAGES-1] = vld[STAGES-1] & out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = vld[k] & (~vld[k+1] | adv[k+1]);
        end
        load[0] = in_valid & in_ready;
        for (int k = 1; k < STAGES; k++) begin
            load[k] = adv[k-1];
        end
    end

    assign in_ready = ~flush & (~vld[0] | adv[0]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld     <= '0;
            flags_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                op_a[k] <= '0;
                op_b[k] <= '0;
                op_r[k] <= '0;
                op_c[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (flush) begin
                    vld[k] <= 1'b0;
                end else if (load[k]) begin
                    vld[k] <= 1'b1;
                end else if (adv[k]) begin
                    vld[k] <= 1'b0;
                end
                if (load[k] && !flush) begin
                    op_a[k] <= src_a[k];
                    op_b[k] <= src_b[k];
                    op_r[k] <= nxt_r[k];
                    op_c[k] <= nxt_c[k];
                end
            end
            if (load[STAGES-1] && !flush) begin
                flags_q <= nxt_flags;
            end
        end
    end

    assign out_valid = vld[STAGES-1];
    assign sum       = op_r[STAGES-1];
    assign flags     = flags_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub (64-bit, 4 stages): vector table, streaming with
// backpressure, and flush / reset in the middle of a stream.
module tb_pipelined_addsub;
    localparam int W = 64;
    localparam int N = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         c_in;
        logic [W-1:0] exp_sum;
        logic [3:0]   exp_flags;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         c_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic [3:0]   flags;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   saw_in_ready_low = 0;
    vec_t tbl [10];
    vec_t src_q [$];
    logic [71:0] exp_q [$];

    pipelined_addsub #(.WIDTH(W), .STAGES(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected beat required orderly completion", name);
    endtask

    task automatic drive_vec(input vec_t v);
        a    = v.a;
        b    = v.b;
        sub  = v.sub;
        c_in = v.c_in;
    endtask

    // One beat into an idle pipeline: checks acceptance, 4-cycle latency and the result.
    task automatic run_single(input vec_t v);
        int lat;
        @(negedge clk);
        drive_vec(v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        flush     = 1'b0;
        #1;
        check("single_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("single_latency", lat, N);
        check("single_result", {flags, sum}, {v.exp_flags, v.exp_sum});
        @(negedge clk);
        check("single_drained", out_valid, 0);
    endtask

    // Streams src_q against exp_q; mode 0 keeps out_ready high, mode 1 toggles it 1,0,1,0.
    task automatic run_stream(input int mode, input int max_cycles);
        int          cyc = 0;
        int          outstanding = 0;
        logic        held = 1'b0;
        logic [67:0] held_val = '0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && cyc < max_cycles) begin
            @(negedge clk);
            if (src_q.size() != 0) begin
                drive_vec(src_q[0]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            #1;
            if (held) check("stall_hold", {out_valid, flags, sum}, {1'b1, held_val});
            check("in_ready_chain", in_ready, !(outstanding == N && !out_ready));
            if (!in_ready) saw_in_ready_low++;
            held     = out_valid && !out_ready;
            held_val = {flags, sum};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) fail_now("unexpected_out");
                else check("stream_result", {flags, sum}, exp_q.pop_front());
                outstanding--;
            end
            if (in_valid && in_ready) begin
                void'(src_q.pop_front());
                outstanding++;
            end
            cyc++;
        end
        if (src_q.size() != 0 || exp_q.size() != 0) fail_now("stream_timeout");
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        vec_t v;
        tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 4'b0110};
        tbl[1] = '{64'h5, 64'h7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000};
        tbl[2] = '{64'h7, 64'h5, 1'b1, 1'b0, 64'h2, 4'b0010};
        tbl[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 4'b1001};
        tbl[4] = '{64'h1, 64'h1, 1'b0, 1'b1, 64'h3, 4'b0000};
        tbl[5] = '{64'h5, 64'h5, 1'b1, 1'b0, 64'h0, 4'b0110};
        tbl[6] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
        tbl[7] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h1_0000_0000, 4'b0000};
        tbl[8] = '{64'h9, 64'h4, 1'b1, 1'b1, 64'h5, 4'b0010};
        tbl[9] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 4'b0111};

        // Reset held with a beat offered: nothing may come out.
        drive_vec(tbl[0]);
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", {out_valid, flags, sum}, 0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("reset_release_ready", in_ready, 1);
        in_valid = 1'b0;

        for (int i = 0; i < 10; i++) run_single(tbl[i]);

        // Back-to-back table with no backpressure.
        for (int i = 0; i < 10; i++) begin
            src_q.push_back(tbl[i]);
            exp_q.push_back({4'h0, tbl[i].exp_flags, tbl[i].exp_sum});
        end
        run_stream(0, 200);

        // Eight beats with out_ready toggling.
        saw_in_ready_low = 0;
        for (int i = 0; i < 8; i++) begin
            v.a = W'(i);
            v.b = W'(i) * 64'h1_0000_0001;
            v.sub = 1'b0;
            v.c_in = 1'b0;
            v.exp_sum = v.a + v.b;
            v.exp_flags = {1'b0, (i == 0), 2'b00};
            src_q.push_back(v);
            exp_q.push_back({4'h0, v.exp_flags, v.exp_sum});
        end
        run_stream(1, 200);
        check("backpressure_full", saw_in_ready_low != 0, 1);

        // Flush with three beats in flight, plus a beat offered on the flush edge.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_vec(tbl[i]);
            in_valid = 1'b1;
            #1;
            check("flush_pre_ready", in_ready, 1);
        end
        @(negedge clk);
        drive_vec(tbl[3]);
        flush = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check("flush_no_out", out_valid, 0);
        end
        run_single(tbl[4]);

        // Reset pulse with a full, stalled pipeline.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_vec(tbl[i]);
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("rst_pre_out_valid", out_valid, 1);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_async_out", {out_valid, flags, sum}, 0);
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("rst_no_out", out_valid, 0);
        end
        run_single(tbl[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish required finish within bound");
        $fatal(1);
    end

endmodule
